// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - default parameters for the brightness/output-enable timer
package params_pkg;
    localparam int BRIGHTNESS_LEVELS                = 4;
    localparam int BRIGHTNESS_BASE_TIMEOUT          = 10;
    localparam int BRIGHTNESS_STATE_TIMEOUT_OVERLAP = 2;
    localparam int DIM_BITS                         = 8;
    localparam int BLANK_CYCLES                     = 1;
endpackage

// File: rtl/plane_index_encoder.sv
// rtl/plane_index_encoder.sv - one-hot plane mask to index, highest set bit wins
module plane_index_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] index,
    output logic             zero,
    output logic             multi
);
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign zero  = (mask == '0);
    assign multi = |(mask & (mask - WIDTH'(1)));
endmodule

// File: rtl/brightness_oe_timer.sv
// rtl/brightness_oe_timer.sv - binary-weighted plane window timer with blanking, dimming and overlap flag
module brightness_oe_timer
    import params_pkg::*;
#(
    parameter int BRIGHTNESS_LEVELS                = params_pkg::BRIGHTNESS_LEVELS,
    parameter int BRIGHTNESS_BASE_TIMEOUT          = params_pkg::BRIGHTNESS_BASE_TIMEOUT,
    parameter int BRIGHTNESS_STATE_TIMEOUT_OVERLAP = params_pkg::BRIGHTNESS_STATE_TIMEOUT_OVERLAP,
    parameter int DIM_BITS                         = params_pkg::DIM_BITS,
    parameter int BLANK_CYCLES                     = params_pkg::BLANK_CYCLES,
    parameter int _UNUSED                          = 0
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         row_latch,
    input  logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active,
    input  logic [DIM_BITS-1:0]          global_dim,
    output logic                         output_enable,
    output logic                         exceeded_overlap_time,
    output logic                         plane_done,
    output logic                         busy,
    output logic                         mask_error
);
    localparam int CNT_W  = $clog2((BRIGHTNESS_BASE_TIMEOUT << (BRIGHTNESS_LEVELS - 1)) + 1);
    localparam int IDX_W  = (BRIGHTNESS_LEVELS > 1) ? $clog2(BRIGHTNESS_LEVELS) : 1;
    localparam int BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam int PROD_W = CNT_W + DIM_BITS + 1;
    localparam logic [CNT_W-1:0] T0_W = CNT_W'(BRIGHTNESS_BASE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON,
        ST_TAIL
    } state_t;

    logic unused_param;
    assign unused_param = (_UNUSED != 0);

    logic [IDX_W-1:0] plane_idx;
    logic             mask_zero;
    logic             mask_multi;

    plane_index_encoder #(
        .WIDTH (BRIGHTNESS_LEVELS),
        .IDX_W (IDX_W)
    ) u_plane_index_encoder (
        .mask  (brightness_mask_active),
        .index (plane_idx),
        .zero  (mask_zero),
        .multi (mask_multi)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   e_q, e_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [CNT_W-1:0]   t_q, t_d;
    logic [CNT_W-1:0]   on_len_q, on_len_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic               ex_q, ex_d;
    logic               err_q, err_d;

    logic               oe_q, oe_d;
    logic               exc_q, exc_d;
    logic               pd_q, pd_d;
    logic               busy_q, busy_d;
    logic               merr_q, merr_d;

    logic [CNT_W-1:0]   t_new;
    logic [PROD_W-1:0]  dim_p1;
    logic [PROD_W-1:0]  prod;
    logic [CNT_W-1:0]   on_len_new;
    logic [CNT_W-1:0]   thr_new;

    // Window parameters for a fresh latch; ON_LEN never exceeds T so it fits in CNT_W.
    always_comb begin
        t_new      = T0_W << plane_idx;
        dim_p1     = PROD_W'(global_dim) + PROD_W'(1);
        prod       = PROD_W'(t_new) * dim_p1;
        on_len_new = CNT_W'(prod >> DIM_BITS);
        if (BRIGHTNESS_STATE_TIMEOUT_OVERLAP >= int'(t_new)) begin
            thr_new = CNT_W'(1);
        end else begin
            thr_new = t_new - CNT_W'(BRIGHTNESS_STATE_TIMEOUT_OVERLAP);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            e_q      <= '0;
            blk_q    <= '0;
            t_q      <= '0;
            on_len_q <= '0;
            thr_q    <= '0;
            ex_q     <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            blk_q    <= blk_d;
            t_q      <= t_d;
            on_len_q <= on_len_d;
            thr_q    <= thr_d;
            ex_q     <= ex_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        blk_d    = blk_q;
        t_d      = t_q;
        on_len_d = on_len_q;
        thr_d    = thr_q;
        ex_d     = ex_q;
        err_d    = 1'b0;
        if (row_latch) begin
            err_d = mask_zero | mask_multi;
            if (mask_zero) begin
                state_d = ST_IDLE;
                e_d     = '0;
                ex_d    = 1'b1;
            end else begin
                t_d      = t_new;
                on_len_d = on_len_new;
                thr_d    = thr_new;
                blk_d    = BLK_W'(1);
                if (BLANK_CYCLES == 0) begin
                    e_d     = CNT_W'(1);
                    state_d = (on_len_new != '0) ? ST_ON : ST_TAIL;
                    ex_d    = (thr_new == CNT_W'(1));
                end else begin
                    e_d     = '0;
                    state_d = ST_BLANK;
                    ex_d    = 1'b0;
                end
            end
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (blk_q == BLK_W'(BLANK_CYCLES)) begin
                        e_d     = CNT_W'(1);
                        state_d = (on_len_q != '0) ? ST_ON : ST_TAIL;
                        ex_d    = ex_q | (thr_q == CNT_W'(1));
                    end else begin
                        blk_d = blk_q + BLK_W'(1);
                    end
                end
                ST_ON, ST_TAIL: begin
                    if (e_q == t_q) begin
                        state_d = ST_IDLE;
                        e_d     = '0;
                    end else begin
                        e_d     = e_q + CNT_W'(1);
                        state_d = (e_d <= on_len_q) ? ST_ON : ST_TAIL;
                        ex_d    = ex_q | (e_d >= thr_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are registered one cycle behind the internal state.
    always_comb begin
        oe_d   = (state_q == ST_ON);
        exc_d  = ex_q;
        pd_d   = ((state_q == ST_ON) || (state_q == ST_TAIL)) && (e_q == t_q);
        busy_d = (state_q != ST_IDLE);
        merr_d = err_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            oe_q   <= 1'b0;
            exc_q  <= 1'b1;
            pd_q   <= 1'b0;
            busy_q <= 1'b0;
            merr_q <= 1'b0;
        end else begin
            oe_q   <= oe_d;
            exc_q  <= exc_d;
            pd_q   <= pd_d;
            busy_q <= busy_d;
            merr_q <= merr_d;
        end
    end

    assign output_enable         = oe_q;
    assign exceeded_overlap_time = exc_q;
    assign plane_done            = pd_q;
    assign busy                  = busy_q;
    assign mask_error            = merr_q;
endmodule

// File: tb/tb_brightness_oe_timer.sv
// tb/tb_brightness_oe_timer.sv - directed bench for brightness_oe_timer
module tb_brightness_oe_timer;
    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       row_latch = 1'b0;
    logic [3:0] brightness_mask_active = '0;
    logic [7:0] global_dim = '0;
    logic       output_enable;
    logic       exceeded_overlap_time;
    logic       plane_done;
    logic       busy;
    logic       mask_error;

    int total = 0;
    int bad = 0;

    brightness_oe_timer #(
        .BRIGHTNESS_LEVELS                (4),
        .BRIGHTNESS_BASE_TIMEOUT          (10),
        .BRIGHTNESS_STATE_TIMEOUT_OVERLAP (2),
        .DIM_BITS                         (8),
        .BLANK_CYCLES                     (1),
        ._UNUSED                          (0)
    ) dut (
        .clk_in                 (clk_in),
        .reset                  (reset),
        .row_latch              (row_latch),
        .brightness_mask_active (brightness_mask_active),
        .global_dim             (global_dim),
        .output_enable          (output_enable),
        .exceeded_overlap_time  (exceeded_overlap_time),
        .plane_done             (plane_done),
        .busy                   (busy),
        .mask_error             (mask_error)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Edge 0 samples the latch; the first negedge afterwards is cycle 0.
    task automatic latch(input logic [3:0] mask, input logic [7:0] dim);
        @(negedge clk_in);
        row_latch              = 1'b1;
        brightness_mask_active = mask;
        global_dim             = dim;
        @(posedge clk_in);
        #1;
        row_latch = 1'b0;
    endtask

    task automatic watch(input string tag, input int ncyc, input int oe_first, input int oe_last,
                         input int ex_cycle, input int done_cycle, input logic err_exp);
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk_in);
            if (k >= 1) begin
                chk($sformatf("%s oe c%0d", tag, k), 32'(output_enable),
                    32'(k >= oe_first && k <= oe_last));
                chk($sformatf("%s done c%0d", tag, k), 32'(plane_done), 32'(k == done_cycle));
                chk($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'(k <= done_cycle));
                chk($sformatf("%s exc c%0d", tag, k), 32'(exceeded_overlap_time),
                    32'(k >= ex_cycle));
                chk($sformatf("%s merr c%0d", tag, k), 32'(mask_error), 32'(k == 1 && err_exp));
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        chk("rst oe", 32'(output_enable), 32'd0);
        chk("rst exc", 32'(exceeded_overlap_time), 32'd1);
        chk("rst done", 32'(plane_done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst merr", 32'(mask_error), 32'd0);

        // Plane 1, full duty: T=20, ON_LEN=20
        latch(4'b0010, 8'd255);
        watch("p1full", 24, 2, 21, 19, 21, 1'b0);

        // Plane 3, half duty: T=80, ON_LEN=40
        latch(4'b1000, 8'd127);
        watch("p3half", 84, 2, 41, 79, 81, 1'b0);

        // Plane 0, dim 0: T=10, ON_LEN=0
        latch(4'b0001, 8'd0);
        watch("p0dark", 14, 2, 1, 9, 11, 1'b0);

        // Abort plane 2 at cycle 10 with plane 0 full duty
        latch(4'b0100, 8'd255);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk_in);
        end
        chk("abort pre oe", 32'(output_enable), 32'd1);
        chk("abort pre busy", 32'(busy), 32'd1);
        latch(4'b0001, 8'd255);
        watch("abort", 35, 2, 11, 9, 11, 1'b0);

        // Zero mask: error pulse, no window
        latch(4'b0000, 8'd255);
        watch("zero", 5, 2, 1, 0, 0, 1'b1);

        // Two bits set: highest wins -> plane 2, T=40
        latch(4'b0110, 8'd255);
        watch("multi", 44, 2, 41, 39, 41, 1'b1);

        // Reset at cycle 5 of a plane-3 window
        latch(4'b1000, 8'd255);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk_in);
        end
        chk("rstmid pre oe", 32'(output_enable), 32'd1);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        chk("rstmid oe", 32'(output_enable), 32'd0);
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid exc", 32'(exceeded_overlap_time), 32'd1);
        chk("rstmid done", 32'(plane_done), 32'd0);
        for (int k = 7; k <= 95; k++) begin
            @(negedge clk_in);
            chk($sformatf("rstmid done c%0d", k), 32'(plane_done), 32'd0);
            chk($sformatf("rstmid busy c%0d", k), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
